// File: rtl/timer_unit.sv
// Architectural counter reads (VL/VH/ID) and the TCFG/TVAL/TICLR countdown timer.
// The read data, the timer state and the interrupt are all registered.
module timer_unit #(
  parameter int          TIMER_N   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_cnt,
  input  logic        i_rd_req,
  input  logic [1:0]  i_rd_sel,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  input  logic        i_tid_we,
  input  logic [31:0] i_tid_wdata,
  input  logic        i_tcfg_we,
  input  logic [31:0] i_tcfg_wdata,
  input  logic        i_ticlr_we,
  input  logic [31:0] i_ticlr_wdata,
  output logic [31:0] o_tcfg,
  output logic [31:0] o_tval,
  output logic        o_timer_int
);

  localparam logic [1:0] SEL_VL = 2'b00;
  localparam logic [1:0] SEL_VH = 2'b01;
  localparam logic [1:0] SEL_ID = 2'b10;

  logic [TIMER_N-1:0] r_tcfg, r_tval;
  logic               r_armed, r_int;
  logic [31:0]        r_tid, r_hi_snap;
  logic               r_snap_vld;
  logic               r_rd_valid;
  logic [31:0]        r_rd_data;

  logic [TIMER_N-1:0] w_reload, w_wr_reload;
  logic               w_expire;
  logic [31:0]        w_rd_data;
  logic               w_unused_bits;

  assign w_reload    = {r_tcfg[TIMER_N-1:2], 2'b00};
  assign w_wr_reload = {i_tcfg_wdata[TIMER_N-1:2], 2'b00};
  // A TCFG write in the same cycle suppresses the expiry.
  assign w_expire    = r_armed && (r_tval == '0) && !i_tcfg_we;
  assign w_unused_bits = ^{i_ticlr_wdata[31:1], i_tcfg_wdata};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tcfg  <= '0;
      r_tval  <= '0;
      r_armed <= 1'b0;
    end else if (i_tcfg_we) begin
      r_tcfg  <= i_tcfg_wdata[TIMER_N-1:0];
      r_tval  <= w_wr_reload;
      r_armed <= i_tcfg_wdata[0];
    end else if (r_armed) begin
      if (r_tval != '0) begin
        r_tval <= r_tval - TIMER_N'(1);
      end else if (r_tcfg[1]) begin
        r_tval <= w_reload;
      end else begin
        r_armed <= 1'b0;
      end
    end
  end

  // Expiry set outranks a same-cycle TICLR clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             r_int <= 1'b0;
    else if (w_expire)                     r_int <= 1'b1;
    else if (i_ticlr_we && i_ticlr_wdata[0]) r_int <= 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_tid <= TID_RESET;
    else if (i_tid_we) r_tid <= i_tid_wdata;
  end

  always_comb begin
    w_rd_data = '0;
    case (i_rd_sel)
      SEL_VL:  w_rd_data = i_cnt[31:0];
      SEL_VH:  w_rd_data = r_snap_vld ? r_hi_snap : i_cnt[63:32];
      SEL_ID:  w_rd_data = r_tid;
      default: w_rd_data = '0;
    endcase
  end

  // VL snapshots the high word so a following VH stays coherent across a carry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_hi_snap  <= '0;
      r_snap_vld <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_req;
      if (i_rd_req) begin
        r_rd_data <= w_rd_data;
        if (i_rd_sel == SEL_VL) begin
          r_hi_snap  <= i_cnt[63:32];
          r_snap_vld <= 1'b1;
        end else if (i_rd_sel == SEL_VH) begin
          r_snap_vld <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_tcfg = '0;
    o_tval = '0;
    o_tcfg[TIMER_N-1:0] = r_tcfg;
    o_tval[TIMER_N-1:0] = r_tval;
  end

  assign o_timer_int = r_int;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: counter reads, one-shot/periodic timer, priorities, reset.
module tb_timer_unit;

  localparam logic [31:0] TIDR = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cnt;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        tid_we, tcfg_we, ticlr_we;
  logic [31:0] tid_wdata, tcfg_wdata, ticlr_wdata;
  logic [31:0] tcfg, tval;
  logic        timer_int;

  int n_cmp = 0;
  int n_bad = 0;

  timer_unit #(.TIMER_N(32), .TID_RESET(TIDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt),
    .i_rd_req(rd_req), .i_rd_sel(rd_sel),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_tid_we(tid_we), .i_tid_wdata(tid_wdata),
    .i_tcfg_we(tcfg_we), .i_tcfg_wdata(tcfg_wdata),
    .i_ticlr_we(ticlr_we), .i_ticlr_wdata(ticlr_wdata),
    .o_tcfg(tcfg), .o_tval(tval), .o_timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 0; rd_sel = 0; tid_we = 0; tcfg_we = 0; ticlr_we = 0;
    tid_wdata = 0; tcfg_wdata = 0; ticlr_wdata = 0;
  endtask

  task automatic clear_int();
    ticlr_we = 1; ticlr_wdata = 1; tick(); ticlr_we = 0; ticlr_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; cnt = 64'h0; idle_inputs();
    tick(); tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid got %0h want 0", rd_valid); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_rd_data got %0h want 0", rd_data); end
    n_cmp++; if (tcfg !== 32'h0) begin n_bad++; $display("FAIL rst_tcfg got %0h want 0", tcfg); end
    n_cmp++; if (tval !== 32'h0) begin n_bad++; $display("FAIL rst_tval got %0h want 0", tval); end
    n_cmp++; if (timer_int !== 1'b0) begin n_bad++; $display("FAIL rst_int got %0h want 0", timer_int); end
    rst = 0; tick();
    rd_req = 1; rd_sel = 2'b10; tick(); rd_req = 0;
    n_cmp++; if (rd_data !== TIDR) begin n_bad++; $display("FAIL rst_tid got %0h want %0h", rd_data, TIDR); end
    n_cmp++; if (tval !== 32'h0) begin n_bad++; $display("FAIL rst_idle_tval got %0h want 0", tval); end
  endtask

  task automatic test_coherent();
    cnt = 64'h0000_0000_FFFF_FFFF; rd_req = 1; rd_sel = 2'b00; tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL coh_vl got v=%0h d=%0h want v=1 d=ffffffff", rd_valid, rd_data); end
    cnt = 64'h0000_0001_0000_0000; rd_sel = 2'b01; tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin n_bad++; $display("FAIL coh_vh got v=%0h d=%0h want v=1 d=0", rd_valid, rd_data); end
    // snapshot consumed: next VH is live
    cnt = 64'h0000_0007_0000_0001; tick();
    n_cmp++; if (rd_data !== 32'h7) begin n_bad++; $display("FAIL live_vh got %0h want 7", rd_data); end
    rd_req = 0; tick();
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'h7) begin n_bad++; $display("FAIL rd_idle got v=%0h d=%0h want v=0 d=7", rd_valid, rd_data); end
  endtask

  task automatic test_back_to_back();
    cnt = 64'h1111_2222_3333_4444;
    rd_req = 1; rd_sel = 2'b10; tid_we = 1; tid_wdata = 32'hDEAD_BEEF; tick();
    tid_we = 0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== TIDR) begin n_bad++; $display("FAIL b2b_old_tid got v=%0h d=%0h want v=1 d=%0h", rd_valid, rd_data, TIDR); end
    rd_sel = 2'b00; tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h3333_4444) begin n_bad++; $display("FAIL b2b_vl got v=%0h d=%0h want v=1 d=33334444", rd_valid, rd_data); end
    rd_sel = 2'b11; tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin n_bad++; $display("FAIL b2b_rsvd got v=%0h d=%0h want v=1 d=0", rd_valid, rd_data); end
    rd_sel = 2'b10; tick();
    n_cmp++; if (rd_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_new_tid got %0h want deadbeef", rd_data); end
    rd_req = 0; tick();
  endtask

  task automatic test_oneshot();
    tcfg_we = 1; tcfg_wdata = 32'h0000_0011; tick(); tcfg_we = 0;
    n_cmp++; if (tcfg !== 32'h11) begin n_bad++; $display("FAIL os_tcfg got %0h want 11", tcfg); end
    for (int j = 1; j <= 17; j++) begin
      if (j > 1) tick();
      n_cmp++; if (tval !== 32'(17 - j) || timer_int !== 1'b0) begin n_bad++; $display("FAIL os_count j=%0d got tval=%0d int=%0h want tval=%0d int=0", j, tval, timer_int, 17 - j); end
    end
    tick();
    n_cmp++; if (timer_int !== 1'b1 || tval !== 32'h0) begin n_bad++; $display("FAIL os_fire got int=%0h tval=%0d want int=1 tval=0", timer_int, tval); end
    ticlr_we = 1; ticlr_wdata = 32'hFFFF_FFFE; tick();
    n_cmp++; if (timer_int !== 1'b1) begin n_bad++; $display("FAIL os_clr_bit0_0 got %0h want 1", timer_int); end
    ticlr_wdata = 32'h1; tick(); ticlr_we = 0; ticlr_wdata = 0;
    n_cmp++; if (timer_int !== 1'b0) begin n_bad++; $display("FAIL os_clr got %0h want 0", timer_int); end
    repeat (5) tick();
    n_cmp++; if (timer_int !== 1'b0 || tval !== 32'h0) begin n_bad++; $display("FAIL os_no_refire got int=%0h tval=%0d want int=0 tval=0", timer_int, tval); end
  endtask

  task automatic test_periodic();
    logic exp_int;
    tcfg_we = 1; tcfg_wdata = 32'h0000_000B; tick(); tcfg_we = 0;
    n_cmp++; if (tval !== 32'd8) begin n_bad++; $display("FAIL per_load got %0d want 8", tval); end
    for (int j = 2; j <= 28; j++) begin
      // clear at 12; clear at 19 collides with an expiry
      ticlr_we = (j == 12 || j == 19); ticlr_wdata = 32'(ticlr_we);
      tick();
      ticlr_we = 0; ticlr_wdata = 0;
      exp_int = (j >= 10 && j < 12) || (j >= 19);
      n_cmp++; if (tval !== 32'(8 - ((j - 1) % 9)) || timer_int !== exp_int) begin n_bad++; $display("FAIL per_seq j=%0d got tval=%0d int=%0h want tval=%0d int=%0h", j, tval, timer_int, 8 - ((j - 1) % 9), exp_int); end
    end
    tcfg_we = 1; tcfg_wdata = 32'h0; tick(); tcfg_we = 0;
    clear_int();
  endtask

  task automatic test_rewrite();
    tcfg_we = 1; tcfg_wdata = 32'h0000_0011; tick(); tcfg_we = 0;
    repeat (16) tick();
    n_cmp++; if (tval !== 32'h0) begin n_bad++; $display("FAIL rw_zero got %0d want 0", tval); end
    tcfg_we = 1; tcfg_wdata = 32'h0000_0015; tick(); tcfg_we = 0;
    n_cmp++; if (tval !== 32'd20 || timer_int !== 1'b0) begin n_bad++; $display("FAIL rw_load got tval=%0d int=%0h want tval=20 int=0", tval, timer_int); end
    tick();
    n_cmp++; if (tval !== 32'd19 || timer_int !== 1'b0) begin n_bad++; $display("FAIL rw_count got tval=%0d int=%0h want tval=19 int=0", tval, timer_int); end
    tcfg_we = 1; tcfg_wdata = 32'h0000_0010; tick(); tcfg_we = 0;
    repeat (3) tick();
    n_cmp++; if (tval !== 32'd16 || tcfg !== 32'h10 || timer_int !== 1'b0) begin n_bad++; $display("FAIL rw_en0 got tval=%0d tcfg=%0h int=%0h want tval=16 tcfg=10 int=0", tval, tcfg, timer_int); end
  endtask

  task automatic test_r0();
    tcfg_we = 1; tcfg_wdata = 32'h0000_0001; tick(); tcfg_we = 0;
    n_cmp++; if (tval !== 32'h0 || timer_int !== 1'b0) begin n_bad++; $display("FAIL r0_t1 got tval=%0d int=%0h want tval=0 int=0", tval, timer_int); end
    tick();
    n_cmp++; if (timer_int !== 1'b1) begin n_bad++; $display("FAIL r0_t2 got %0h want 1", timer_int); end
    // En=0 write leaves a pending interrupt alone
    tcfg_we = 1; tcfg_wdata = 32'h0000_0020; tick(); tcfg_we = 0;
    n_cmp++; if (timer_int !== 1'b1 || tval !== 32'd32) begin n_bad++; $display("FAIL en0_keep got int=%0h tval=%0d want int=1 tval=32", timer_int, tval); end
    clear_int();
  endtask

  task automatic test_reset_mid();
    tcfg_we = 1; tcfg_wdata = 32'h0000_000B; tick(); tcfg_we = 0;
    repeat (12) tick();
    cnt = 64'h0000_00AA_0000_0005; rd_req = 1; rd_sel = 2'b00; tick(); rd_req = 0;
    n_cmp++; if (timer_int !== 1'b1 || tval === 32'h0) begin n_bad++; $display("FAIL mid_pre got int=%0h tval=%0d want int=1 tval!=0", timer_int, tval); end
    rd_req = 1; rd_sel = 2'b00;
    #2 rst = 1; #1;
    n_cmp++; if (tval !== 0 || tcfg !== 0 || timer_int !== 0 || rd_valid !== 0) begin n_bad++; $display("FAIL mid_async got tval=%0d tcfg=%0h int=%0h v=%0h want all 0", tval, tcfg, timer_int, rd_valid); end
    rd_req = 0;
    tick();
    rst = 0;
    cnt = 64'h1234_5678_9ABC_DEF0; rd_req = 1; rd_sel = 2'b01; tick(); rd_req = 0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL mid_live_vh got v=%0h d=%0h want v=1 d=12345678", rd_valid, rd_data); end
    tick();
    n_cmp++; if (tval !== 0 || timer_int !== 0) begin n_bad++; $display("FAIL mid_idle got tval=%0d int=%0h want 0 0", tval, timer_int); end
  endtask

  initial begin
    test_reset();
    test_coherent();
    test_back_to_back();
    test_oneshot();
    test_periodic();
    test_rewrite();
    test_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
